ballot_controller: RTL and testbench
====================================

# ballot_controller

Parametrised successor to the four-button voting top level. It gates every vote behind a fingerprint-authenticated session and keeps one saturating tally per candidate for `NUM_CANDIDATES` candidates. A result mode shows a selected candidate's tally and tracks the current leader. It sits between the Arduino fingerprint interface and the LED bank, and replaces the fixed four-channel button/logger/mode chain.

## Interface

Parameters:
- `NUM_CANDIDATES`, default 4: number of candidate buttons and tallies, 2..16.
- `COUNT_WIDTH`, default 8: width of each tally and of `LED`.
- `VOTE_TIMEOUT`, default 255: cycles an authenticated session stays armed without a vote, 1..65535.

Ports (`SEL_W` = `$clog2(NUM_CANDIDATES)`):
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `mode` in 1: 0 = voting, 1 = result display.
- `fingerprint_valid` in 1: level from the Arduino; its rising edge opens a session.
- `buttons` in `NUM_CANDIDATES`: candidate buttons, level, already debounced.
- `result_select` in `SEL_W`: candidate whose tally is shown in result mode.
- `LED` out `COUNT_WIDTH`: display output.
- `session_active` out 1: high while in ARMED.
- `vote_accepted` out 1: one-cycle pulse per counted vote.
- `timeout` out 1: one-cycle pulse when a session expires.
- `winner_index` out `SEL_W`: index of the highest tally.
- `tie` out 1: the highest tally is shared and is nonzero.
- `overflow` out 1: sticky; some tally saturated.

## Operation

- Edge detection:
  - Registered previous copies of `fingerprint_valid` and `buttons`.
  - A rising edge is current = 1 while previous = 0.
  - Previous copies reset to all ones, so levels already high when reset releases produce no edge.
- FSM states: IDLE, ARMED, LOCKOUT.
- IDLE to ARMED:
  - Taken on a `fingerprint_valid` rising edge with `mode` = 0.
  - Loads the timer with `VOTE_TIMEOUT`.
- ARMED, exactly one button rising edge:
  - Increments that candidate's tally; pulses `vote_accepted`; goes to LOCKOUT.
- ARMED, two or more simultaneous button rising edges:
  - The vote is spoiled: no tally changes and no pulse; stays ARMED with the timer still running.
- ARMED, timer:
  - With no button edge, the timer decrements each cycle.
  - When the timer is 0, the FSM goes to IDLE and pulses `timeout`.
  - If a valid single edge arrives in the same cycle as timer = 0, the vote wins.
- ARMED, other exits:
  - `mode` = 1 in ARMED goes to IDLE; no vote, no timeout pulse.
  - `fingerprint_valid` dropping does not end the session.
- LOCKOUT to IDLE:
  - Taken only when `fingerprint_valid` = 0 and all buttons = 0 on the same cycle.
  - Prevents a second vote per fingerprint presentation.
- Button edges outside ARMED are ignored.
- Tallies:
  - `COUNT_WIDTH` bits each, reset to 0.
  - At all-ones, a tally holds its value.
  - An accepted vote on a saturated tally still pulses `vote_accepted` and sets `overflow`, which clears only on reset.
- LED:
  - Registered.
  - With `mode` = 1: tally[`result_select`], or 0 if `result_select` ≥ `NUM_CANDIDATES`.
  - With `mode` = 0: all ones for the single cycle `vote_accepted` is high, otherwise 0.
- Leader tracking:
  - `winner_index` is the lowest index holding the maximum tally.
  - `tie` = 1 when two or more candidates hold that maximum and it is > 0.
  - Both are registered from the current tallies.

## Timing

- Reset values: state IDLE, timer 0, all tallies 0, `LED` 0, `session_active` 0, `vote_accepted` 0, `timeout` 0, `winner_index` 0, `tie` 0, `overflow` 0.
- Reset wins over every other event on the same edge and aborts any session.
- A `fingerprint_valid` rise first sampled at edge j gives ARMED and `session_active` = 1 after edge j.
- A session armed at edge j with no vote:
  - Votes are accepted on edges j+1 through j+`VOTE_TIMEOUT`+1.
  - The FSM returns to IDLE at edge j+`VOTE_TIMEOUT`+1, with `timeout` high for the following cycle.
- A button rise first sampled at edge k in ARMED:
  - The tally, `vote_accepted`, LED all-ones and LOCKOUT are all visible after edge k.
  - `winner_index` and `tie` reflect the new tally after edge k+1.
- A `mode` change is reflected on `LED` one cycle after sampling.
- `result_select` changes reach `LED` with one cycle of latency.

## Test plan

- After reset release, raise `fingerprint_valid`, then `buttons`=0b0100 -> tally2 = 1, `vote_accepted` high for 1 cycle, LED = 0xFF for 1 cycle, state LOCKOUT.
- In LOCKOUT, press button 0 again, then drop all inputs -> no count change; IDLE is re-entered only after `fingerprint_valid` = 0 and `buttons` = 0.
- With `VOTE_TIMEOUT`=5, arm and never press -> `timeout` pulses exactly 6 cycles after arming; a press afterwards is not counted.
- In ARMED, `buttons` 0b0000 then 0b0011 on the same cycle -> no tally change, still ARMED; a later single press of button 3 counts.
- With `COUNT_WIDTH`=4, cast 17 votes for candidate 1 -> tally1 = 15, `overflow` = 1, `winner_index` = 1, `tie` = 0.
- Give candidates 0 and 2 three votes each, then set `mode`=1 and `result_select`=2 -> LED = 3, `winner_index` = 0, `tie` = 1. Set `result_select`=7 with `NUM_CANDIDATES`=5 -> LED = 0. Assert reset mid-session -> all outputs return to their reset values.

Source files
------------

// File: rtl/ballot_controller.sv
// Fingerprint-gated voting controller with one saturating tally per candidate.
// It also provides a result display and leader/tie tracking.
module ballot_controller #(
    parameter int NUM_CANDIDATES = 4,
    parameter int COUNT_WIDTH    = 8,
    parameter int VOTE_TIMEOUT   = 255,
    localparam int SEL_W         = $clog2(NUM_CANDIDATES)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mode,
    input  logic                      fingerprint_valid,
    input  logic [NUM_CANDIDATES-1:0] buttons,
    input  logic [SEL_W-1:0]          result_select,
    output logic [COUNT_WIDTH-1:0]    LED,
    output logic                      session_active,
    output logic                      vote_accepted,
    output logic                      timeout,
    output logic [SEL_W-1:0]          winner_index,
    output logic                      tie,
    output logic                      overflow
);

    localparam int          TIMER_W    = 16;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(VOTE_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_LOCKOUT
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [TIMER_W-1:0]        r_timer;
    logic [TIMER_W-1:0]        w_timer_next;

    logic                      r_fp_prev;
    logic [NUM_CANDIDATES-1:0] r_btn_prev;
    logic                      w_fp_rise;
    logic [NUM_CANDIDATES-1:0] w_btn_rise;
    logic                      w_single;

    logic                      w_vote;
    logic                      w_expire;
    logic [NUM_CANDIDATES-1:0] w_inc;
    logic [NUM_CANDIDATES-1:0] w_sat;

    logic [COUNT_WIDTH-1:0]    r_tally [NUM_CANDIDATES];
    logic [COUNT_WIDTH-1:0]    w_sel_tally;
    logic [COUNT_WIDTH-1:0]    w_led_next;
    logic [COUNT_WIDTH-1:0]    w_max;
    logic [SEL_W-1:0]          w_lead;
    logic                      w_dup;

    logic                      r_vote;
    logic                      r_timeout;
    logic [COUNT_WIDTH-1:0]    r_led;
    logic [SEL_W-1:0]          r_winner;
    logic                      r_tie;
    logic                      r_overflow;

    // Previous copies start high so levels held through reset do not look like edges.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fp_prev  <= 1'b1;
            r_btn_prev <= '1;
        end else begin
            r_fp_prev  <= fingerprint_valid;
            r_btn_prev <= buttons;
        end
    end

    assign w_fp_rise  = fingerprint_valid & ~r_fp_prev;
    assign w_btn_rise = buttons & ~r_btn_prev;
    assign w_single   = (w_btn_rise != '0) &&
                        ((w_btn_rise & (w_btn_rise - NUM_CANDIDATES'(1))) == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    // A single vote edge beats expiry on the cycle the timer reaches zero.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_vote       = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fp_rise && !mode) begin
                    w_state_next = S_ARMED;
                    w_timer_next = TIMER_LOAD;
                end
            end
            S_ARMED: begin
                if (mode) begin
                    w_state_next = S_IDLE;
                end else if (w_single) begin
                    w_vote       = 1'b1;
                    w_state_next = S_LOCKOUT;
                end else if (r_timer == '0) begin
                    w_expire     = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_next = r_timer - TIMER_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (!fingerprint_valid && (buttons == '0)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CANDIDATES; gi++) begin : g_cand
            assign w_inc[gi] = w_vote & w_btn_rise[gi];
            assign w_sat[gi] = &r_tally[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
                r_tally[i] <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
                if (w_inc[i] && !w_sat[i]) begin
                    r_tally[i] <= r_tally[i] + COUNT_WIDTH'(1);
                end
            end
            r_overflow <= r_overflow | (|(w_inc & w_sat));
        end
    end

    // Out-of-range selections match no candidate and leave the display at zero.
    always_comb begin
        w_sel_tally = '0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            if (result_select == SEL_W'(i)) begin
                w_sel_tally = r_tally[i];
            end
        end
    end

    assign w_led_next = mode ? w_sel_tally : (w_vote ? '1 : '0);

    // Strict greater-than keeps the lowest index on equal tallies.
    always_comb begin
        w_max  = r_tally[0];
        w_lead = '0;
        w_dup  = 1'b0;
        for (int i = 1; i < NUM_CANDIDATES; i++) begin
            if (r_tally[i] > w_max) begin
                w_max  = r_tally[i];
                w_lead = SEL_W'(i);
                w_dup  = 1'b0;
            end else if (r_tally[i] == w_max) begin
                w_dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_vote    <= 1'b0;
            r_timeout <= 1'b0;
            r_led     <= '0;
            r_winner  <= '0;
            r_tie     <= 1'b0;
        end else begin
            r_vote    <= w_vote;
            r_timeout <= w_expire;
            r_led     <= w_led_next;
            r_winner  <= w_lead;
            r_tie     <= w_dup && (w_max != '0);
        end
    end

    assign LED            = r_led;
    assign session_active = (r_state == S_ARMED);
    assign vote_accepted  = r_vote;
    assign timeout        = r_timeout;
    assign winner_index   = r_winner;
    assign tie            = r_tie;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller: 5 candidates, 4-bit tallies, 5-cycle session timeout.
module tb_ballot_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic       fingerprint_valid;
    logic [4:0] buttons;
    logic [2:0] result_select;
    logic [3:0] LED;
    logic       session_active;
    logic       vote_accepted;
    logic       timeout;
    logic [2:0] winner_index;
    logic       tie;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    ballot_controller #(
        .NUM_CANDIDATES(5),
        .COUNT_WIDTH   (4),
        .VOTE_TIMEOUT  (5)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .mode             (mode),
        .fingerprint_valid(fingerprint_valid),
        .buttons          (buttons),
        .result_select    (result_select),
        .LED              (LED),
        .session_active   (session_active),
        .vote_accepted    (vote_accepted),
        .timeout          (timeout),
        .winner_index     (winner_index),
        .tie              (tie),
        .overflow         (overflow)
    );

    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_vec({tag, "_led"}, int'(LED), 0);
        check_vec({tag, "_session"}, int'(session_active), 0);
        check_vec({tag, "_vote"}, int'(vote_accepted), 0);
        check_vec({tag, "_timeout"}, int'(timeout), 0);
        check_vec({tag, "_winner"}, int'(winner_index), 0);
        check_vec({tag, "_tie"}, int'(tie), 0);
        check_vec({tag, "_overflow"}, int'(overflow), 0);
    endtask

    // Entered from IDLE with all inputs low; leaves the FSM back in IDLE.
    task automatic cast_vote(input int idx);
        logic [4:0] b;
        b = 5'b00001 << idx;
        fingerprint_valid = 1'b1;
        tick();
        check_vec("cv_armed", int'(session_active), 1);
        buttons = b;
        tick();
        check_vec("cv_pulse", int'(vote_accepted), 1);
        check_vec("cv_led", int'(LED), 15);
        fingerprint_valid = 1'b0;
        buttons = '0;
        tick();
    endtask

    task automatic read_tally(input int idx, input int exp);
        mode = 1'b1;
        result_select = 3'(idx);
        tick();
        check_vec($sformatf("tally%0d", idx), int'(LED), exp);
        mode = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        mode = 1'b0;
        fingerprint_valid = 1'b1;
        buttons = '0;
        result_select = '0;
        repeat (3) tick();
        check_reset_state("rst");

        // Fingerprint already high at release must not open a session.
        reset = 1'b1;
        tick();
        tick();
        check_vec("no_edge_at_release", int'(session_active), 0);
        fingerprint_valid = 1'b0;
        tick();

        // Basic vote for candidate 2.
        fingerprint_valid = 1'b1;
        tick();
        check_vec("arm", int'(session_active), 1);
        buttons = 5'b00100;
        tick();
        check_vec("vote2_pulse", int'(vote_accepted), 1);
        check_vec("vote2_led", int'(LED), 15);
        check_vec("vote2_lockout", int'(session_active), 0);
        tick();
        check_vec("vote2_pulse_end", int'(vote_accepted), 0);
        check_vec("vote2_led_end", int'(LED), 0);
        check_vec("vote2_winner", int'(winner_index), 2);
        check_vec("vote2_tie", int'(tie), 0);

        // Lockout: extra presses ignored, exit needs fingerprint and buttons low together.
        buttons = 5'b00000;
        tick();
        buttons = 5'b00001;
        tick();
        check_vec("lock_press", int'(vote_accepted), 0);
        fingerprint_valid = 1'b0;
        tick();
        fingerprint_valid = 1'b1;
        tick();
        check_vec("lock_held", int'(session_active), 0);
        fingerprint_valid = 1'b0;
        buttons = '0;
        tick();
        fingerprint_valid = 1'b1;
        tick();
        check_vec("rearm", int'(session_active), 1);

        // Spoiled double press, then a valid press of button 3.
        buttons = 5'b00011;
        tick();
        check_vec("spoil_pulse", int'(vote_accepted), 0);
        check_vec("spoil_armed", int'(session_active), 1);
        buttons = '0;
        tick();
        buttons = 5'b01000;
        tick();
        check_vec("vote3_pulse", int'(vote_accepted), 1);
        fingerprint_valid = 1'b0;
        buttons = '0;
        tick();

        // Timeout six cycles after arming; later press not counted.
        fingerprint_valid = 1'b1;
        tick();
        check_vec("to_arm", int'(session_active), 1);
        repeat (5) tick();
        check_vec("to_still_armed", int'(session_active), 1);
        check_vec("to_not_yet", int'(timeout), 0);
        tick();
        check_vec("to_idle", int'(session_active), 0);
        check_vec("to_pulse", int'(timeout), 1);
        buttons = 5'b00001;
        tick();
        check_vec("to_pulse_end", int'(timeout), 0);
        check_vec("to_late_press", int'(vote_accepted), 0);
        fingerprint_valid = 1'b0;
        buttons = '0;
        tick();

        // Vote on the final cycle beats the timeout.
        fingerprint_valid = 1'b1;
        tick();
        repeat (5) tick();
        buttons = 5'b00010;
        tick();
        check_vec("last_cycle_vote", int'(vote_accepted), 1);
        check_vec("last_cycle_no_to", int'(timeout), 0);
        fingerprint_valid = 1'b0;
        buttons = '0;
        tick();

        // Mode change ends the session silently.
        fingerprint_valid = 1'b1;
        tick();
        mode = 1'b1;
        tick();
        check_vec("mode_exit", int'(session_active), 0);
        check_vec("mode_exit_to", int'(timeout), 0);
        mode = 1'b0;
        fingerprint_valid = 1'b0;
        tick();

        read_tally(0, 0);
        read_tally(1, 1);
        read_tally(2, 1);
        read_tally(3, 1);

        // Saturation: 16 more votes give candidate 1 seventeen in total.
        repeat (16) cast_vote(1);
        tick();
        check_vec("sat_overflow", int'(overflow), 1);
        check_vec("sat_winner", int'(winner_index), 1);
        check_vec("sat_tie", int'(tie), 0);
        read_tally(1, 15);

        reset = 1'b0;
        tick();
        check_reset_state("rst2");
        reset = 1'b1;
        tick();

        // Tie between candidates 0 and 2.
        repeat (3) cast_vote(0);
        repeat (2) cast_vote(2);
        tick();
        check_vec("pretie_winner", int'(winner_index), 0);
        check_vec("pretie_tie", int'(tie), 0);
        cast_vote(2);
        tick();
        check_vec("tie_winner", int'(winner_index), 0);
        check_vec("tie_flag", int'(tie), 1);
        mode = 1'b1;
        result_select = 3'd2;
        tick();
        check_vec("sel2_led", int'(LED), 3);
        result_select = 3'd7;
        tick();
        check_vec("sel7_led", int'(LED), 0);
        result_select = 3'd0;
        tick();
        check_vec("sel0_led", int'(LED), 3);
        mode = 1'b0;
        tick();
        check_vec("mode0_led", int'(LED), 0);

        // Reset mid-session, with a button edge on the same edge.
        fingerprint_valid = 1'b1;
        tick();
        check_vec("mid_arm", int'(session_active), 1);
        reset = 1'b0;
        buttons = 5'b00001;
        tick();
        check_reset_state("rst3");
        reset = 1'b1;
        buttons = '0;
        fingerprint_valid = 1'b0;
        mode = 1'b1;
        result_select = 3'd0;
        tick();
        check_vec("rst3_tally0", int'(LED), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
